// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one 16-bit ALU through a small FSM. The FSM
// registers the operands and the ALU result. It returns each result on a
// valid/ready response channel. It also maintains the architectural {Z,V,N}
// flag register.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   reqN_valid/ready         request handshake, N = 0 (execute path), 1 (address/debug)
//   reqN_op/a/b              opcode, operand 1, operand 2 / shift amount
//   rsp_valid/ready          response handshake
//   rsp_id/data/flags/err    registered requester id, ALU_Out, {Z,V,N}, Error
//   flag_reg                 architectural flags {Z,V,N}
//   busy                     FSM not in IDLE
//
// state | meaning
// IDLE  | arbitrate; latch the winner's op/a/b/id on the edge
// EXEC  | ALU fed from operand registers; capture result on the edge
// RESP  | rsp_valid high; wait for rsp_ready, then update flag_reg

// ALU: ADD/SUB saturate, RED adds four bytes (mod 256, sign-extended),
// PADDSB does four saturating signed nibble adds. Shifts use in2[3:0].
// Error flags a shift whose amount does not fit in 4 bits.
module alu_core (
  input  logic [15:0] alu_in1,
  input  logic [15:0] alu_in2,
  input  logic [2:0]  opcode,
  output logic [15:0] alu_out,
  output logic [2:0]  flags,
  output logic        error
);
  logic [3:0]  sh;
  logic [15:0] sum, diff, sra_res, ror_res, paddsb;
  logic [7:0]  red_sum;
  logic        add_ovf, sub_ovf;
  logic [4:0]  nib_sum [4];

  assign sh      = alu_in2[3:0];
  assign sum     = alu_in1 + alu_in2;
  assign diff    = alu_in1 - alu_in2;
  assign add_ovf = (alu_in1[15] == alu_in2[15]) && (sum[15] != alu_in1[15]);
  assign sub_ovf = (alu_in1[15] != alu_in2[15]) && (diff[15] != alu_in1[15]);
  assign red_sum = alu_in1[15:8] + alu_in1[7:0] + alu_in2[15:8] + alu_in2[7:0];
  assign sra_res = $signed(alu_in1) >>> sh;
  // Shift by 16 when sh==0 yields 0, so the OR leaves alu_in1 unchanged.
  assign ror_res = (alu_in1 >> sh) | (alu_in1 << (5'd16 - {1'b0, sh}));

  always_comb begin
    paddsb = '0;
    for (int i = 0; i < 4; i++) begin
      nib_sum[i] = {alu_in1[4*i+3], alu_in1[4*i +: 4]} + {alu_in2[4*i+3], alu_in2[4*i +: 4]};
      if (nib_sum[i][4] != nib_sum[i][3])
        paddsb[4*i +: 4] = nib_sum[i][4] ? 4'h8 : 4'h7;
      else
        paddsb[4*i +: 4] = nib_sum[i][3:0];
    end
  end

  always_comb begin
    alu_out = '0;
    case (opcode)
      3'd0: alu_out = add_ovf ? (alu_in1[15] ? 16'h8000 : 16'h7FFF) : sum;
      3'd1: alu_out = sub_ovf ? (alu_in1[15] ? 16'h8000 : 16'h7FFF) : diff;
      3'd2: alu_out = alu_in1 ^ alu_in2;
      3'd3: alu_out = {{8{red_sum[7]}}, red_sum};
      3'd4: alu_out = alu_in1 << sh;
      3'd5: alu_out = sra_res;
      3'd6: alu_out = ror_res;
      default: alu_out = paddsb;
    endcase
  end

  assign flags = {alu_out == 16'h0000,
                  ((opcode == 3'd0) && add_ovf) || ((opcode == 3'd1) && sub_ovf),
                  (opcode <= 3'd1) && alu_out[15]};
  assign error = (opcode >= 3'd4) && (opcode <= 3'd6) && (|alu_in2[15:4]);
endmodule

module alu_arbiter #(
  parameter int PRIO_FIXED = 0,
  parameter int WIDTH      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       rsp_flags,
  output logic             rsp_err,
  output logic [2:0]       flag_reg,
  output logic             busy
);
  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_EXEC = 3'b010,
    S_RESP = 3'b100
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, alu_out;
  logic [2:0]       alu_flags;
  logic             alu_err, id_q, last_grant, accept, handshake;

  alu_core u_alu (
    .alu_in1(a_q),
    .alu_in2(b_q),
    .opcode (op_q),
    .alu_out(alu_out),
    .flags  (alu_flags),
    .error  (alu_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grants are gated by rst so both readies read 0 while reset is held.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == S_IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        if ((PRIO_FIXED != 0) || last_grant) req0_ready = 1'b1;
        else                                 req1_ready = 1'b1;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
    rsp_valid = (state == S_RESP);
    busy      = (state != S_IDLE);
  end

  assign accept    = req0_ready | req1_ready;
  assign handshake = rsp_valid & rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      flag_reg   <= 3'b000;
    end else begin
      if (accept) begin
        op_q       <= req1_ready ? req1_op : req0_op;
        a_q        <= req1_ready ? req1_a  : req0_a;
        b_q        <= req1_ready ? req1_b  : req0_b;
        id_q       <= req1_ready;
        last_grant <= req1_ready;
      end
      if (state == S_EXEC) begin
        rsp_data  <= alu_out;
        rsp_flags <= alu_flags;
        rsp_err   <= alu_err;
        rsp_id    <= id_q;
      end
      if (handshake && !rsp_err) begin
        case (op_q)
          3'd0, 3'd1:             flag_reg <= rsp_flags;
          3'd2, 3'd4, 3'd5, 3'd6: flag_reg[2] <= rsp_flags[2];
          default:                flag_reg <= flag_reg;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req1_valid, rsp_ready;
  logic [2:0] req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, busy;
  logic [15:0] rsp_data;
  logic [2:0] rsp_flags, flag_reg;
  logic fix_req0_ready, fix_req1_ready, fix_rsp_valid, fix_rsp_id, fix_rsp_err, fix_busy;
  logic [15:0] fix_rsp_data;
  logic [2:0] fix_rsp_flags, fix_flag_reg;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.PRIO_FIXED(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .flag_reg(flag_reg), .busy(busy));

  alu_arbiter #(.PRIO_FIXED(1)) u_fix (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fix_req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(fix_req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(fix_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fix_rsp_id), .rsp_data(fix_rsp_data),
    .rsp_flags(fix_rsp_flags), .rsp_err(fix_rsp_err), .flag_reg(fix_flag_reg), .busy(fix_busy));

  typedef struct {
    logic [15:0] data;
    logic [2:0]  flags;
    logic        err;
  } res_t;

  typedef struct {
    logic        id;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] data;
    logic [2:0]  flags;
    logic        err;
    logic [2:0]  fr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the instruction definitions, in plain integer arithmetic.
  function automatic res_t alu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    res_t r;
    int sa, sb, x, sh, na, nb, ns;
    logic v;
    logic [15:0] res;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b) % 16;
    v = 1'b0;
    res = '0;
    case (op)
      3'd0, 3'd1: begin
        x = (op == 3'd0) ? sa + sb : sa - sb;
        if (x > 32767) begin x = 32767; v = 1'b1; end
        else if (x < -32768) begin x = -32768; v = 1'b1; end
        res = x[15:0];
      end
      3'd2: res = a ^ b;
      3'd3: begin
        x = (int'(a[15:8]) + int'(a[7:0]) + int'(b[15:8]) + int'(b[7:0])) % 256;
        if (x >= 128) x = x - 256;
        res = x[15:0];
      end
      3'd4: res = a << sh;
      3'd5: begin x = sa >>> sh; res = x[15:0]; end
      3'd6: begin x = (int'(a) >> sh) | (int'(a) << (16 - sh)); res = x[15:0]; end
      default: begin
        for (int i = 0; i < 4; i++) begin
          na = int'(a[4*i +: 4]); if (na >= 8) na = na - 16;
          nb = int'(b[4*i +: 4]); if (nb >= 8) nb = nb - 16;
          ns = na + nb;
          if (ns > 7) ns = 7;
          if (ns < -8) ns = -8;
          res[4*i +: 4] = ns[3:0];
        end
      end
    endcase
    r.data  = res;
    r.flags = {res == 16'h0000, v, (op <= 3'd1) && res[15]};
    r.err   = (op >= 3'd4) && (op <= 3'd6) && (b > 16'd15);
    return r;
  endfunction

  task automatic drive(input logic id, input logic vld, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    if (id) begin req1_valid = vld; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = vld; req0_op = op; req0_a = a; req0_b = b; end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single operation from idle with rsp_ready high; starts and ends 1 ns after an edge.
  task automatic run_op(input vec_t v);
    drive(v.id, 1'b1, v.op, v.a, v.b);
    #1;
    check("grant", v.id ? req1_ready : req0_ready, 1);
    check("no_other_grant", v.id ? req0_ready : req1_ready, 0);
    tick();
    drive(v.id, 1'b0, v.op, v.a, v.b);
    check("exec_busy", busy, 1);
    check("exec_rsp_valid", rsp_valid, 0);
    tick();
    check("rsp_valid", rsp_valid, 1);
    check("rsp_data", rsp_data, v.data);
    check("rsp_flags", rsp_flags, v.flags);
    check("rsp_err", rsp_err, v.err);
    check("rsp_id", rsp_id, v.id);
    tick();
    check("rsp_done", rsp_valid, 0);
    check("flag_reg", flag_reg, v.fr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  vec_t tbl[$];

  initial begin
    int g_cnt, g_id, fix_cnt;
    logic [15:0] held;
    int m_phase, m_last;
    logic [2:0] m_fr;
    res_t m_exp, r;
    logic m_id, m_op_arith, m_op_z, exp_g0, exp_g1, drop0, drop1;
    logic [2:0] m_opq;

    tbl.push_back('{1'b0, 3'd0, 16'h7000, 16'h7000, 16'h7FFF, 3'b010, 1'b0, 3'b010});
    tbl.push_back('{1'b1, 3'd1, 16'h0005, 16'h0005, 16'h0000, 3'b100, 1'b0, 3'b100});
    tbl.push_back('{1'b1, 3'd2, 16'h8000, 16'h0000, 16'h8000, 3'b000, 1'b0, 3'b000});
    tbl.push_back('{1'b0, 3'd0, 16'h8000, 16'h0001, 16'h8001, 3'b001, 1'b0, 3'b001});
    tbl.push_back('{1'b0, 3'd3, 16'h1234, 16'h5678, 16'h0014, 3'b000, 1'b0, 3'b001});
    tbl.push_back('{1'b1, 3'd1, 16'h8000, 16'h0001, 16'h8000, 3'b011, 1'b0, 3'b011});
    tbl.push_back('{1'b0, 3'd4, 16'h0001, 16'h0004, 16'h0010, 3'b000, 1'b0, 3'b011});
    tbl.push_back('{1'b0, 3'd5, 16'h8000, 16'h0003, 16'hF000, 3'b000, 1'b0, 3'b011});
    tbl.push_back('{1'b1, 3'd6, 16'h0001, 16'h0001, 16'h8000, 3'b000, 1'b0, 3'b011});
    tbl.push_back('{1'b0, 3'd2, 16'h1234, 16'h1234, 16'h0000, 3'b100, 1'b0, 3'b111});
    tbl.push_back('{1'b0, 3'd7, 16'h7777, 16'h1111, 16'h7777, 3'b000, 1'b0, 3'b111});
    tbl.push_back('{1'b1, 3'd4, 16'h0001, 16'h0010, 16'h0001, 3'b000, 1'b1, 3'b111});
    tbl.push_back('{1'b0, 3'd0, 16'h0003, 16'hFFFD, 16'h0000, 3'b100, 1'b0, 3'b100});
    tbl.push_back('{1'b0, 3'd7, 16'h8123, 16'h8F11, 16'h8034, 3'b000, 1'b0, 3'b100});
    tbl.push_back('{1'b1, 3'd3, 16'h4040, 16'h4000, 16'hFFC0, 3'b000, 1'b0, 3'b100});
    tbl.push_back('{1'b0, 3'd5, 16'h8000, 16'h0100, 16'h8000, 3'b000, 1'b1, 3'b100});
    tbl.push_back('{1'b0, 3'd6, 16'h00F0, 16'h0004, 16'h000F, 3'b000, 1'b0, 3'b000});

    // Reset state, with a request pending during reset.
    rst = 1'b1; rsp_ready = 1'b1;
    drive(1'b0, 1'b1, 3'd0, 16'h1111, 16'h2222);
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 16'h0000);
    #3;
    check("rst_ready0", req0_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_flag_reg", flag_reg, 0);
    req0_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    foreach (tbl[i]) run_op(tbl[i]);

    // Both requesters held valid: RR alternates, fixed priority always picks 0.
    do_reset();
    drive(1'b0, 1'b1, 3'd2, 16'h00FF, 16'h0F0F);
    drive(1'b1, 1'b1, 3'd2, 16'hFF00, 16'h0F0F);
    g_cnt = 0; fix_cnt = 0;
    for (int c = 0; c < 18; c++) begin
      #1;
      if (req0_ready || req1_ready) begin
        g_id = req1_ready ? 1 : 0;
        check("rr_order", g_id, g_cnt % 2);
        check("rr_spacing", c, 3 * g_cnt);
        g_cnt++;
      end
      if (fix_req0_ready || fix_req1_ready) begin
        check("fix_grant0", fix_req1_ready, 0);
        fix_cnt++;
      end
      @(posedge clk);
      #0;
    end
    #1;
    check("rr_count", g_cnt, 6);
    check("fix_count", fix_cnt, 6);
    drive(1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 3'd0, 16'h0, 16'h0);
    tick(); tick(); tick();

    // Backpressure with requester 1 waiting.
    do_reset();
    rsp_ready = 1'b0;
    drive(1'b0, 1'b1, 3'd0, 16'h0001, 16'h0002);
    #1;
    check("bp_grant0", req0_ready, 1);
    tick();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    drive(1'b1, 1'b1, 3'd2, 16'h1234, 16'h00FF);
    check("bp_exec_ready1", req1_ready, 0);
    tick();
    held = rsp_data;
    check("bp_data", held, 16'h0003);
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_stable", rsp_data, 16'h0003);
      check("bp_ready1", req1_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_resp_no_accept", req1_ready, 0);
    tick();
    check("bp_idle_accept", req1_ready, 1);
    tick();
    drive(1'b1, 1'b0, 3'd0, 16'h0, 16'h0);
    tick();
    check("bp_rsp1_data", rsp_data, 16'h12CB);
    check("bp_rsp1_id", rsp_id, 1);
    tick();

    // Reset during EXEC discards the operation.
    run_op('{1'b0, 3'd0, 16'h7000, 16'h7000, 16'h7FFF, 3'b010, 1'b0, 3'b010});
    drive(1'b0, 1'b1, 3'd0, 16'h0001, 16'h0001);
    tick();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    check("pre_rst_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_flag_reg", flag_reg, 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("discarded", rsp_valid, 0);
      tick();
    end
    run_op('{1'b0, 3'd4, 16'h0001, 16'h0004, 16'h0010, 3'b000, 1'b0, 3'b000});

    // Randomized traffic against a transaction-level model.
    do_reset();
    m_phase = 0; m_last = 1; m_fr = 3'b000; m_id = 1'b0; m_opq = 3'd0;
    m_exp = '{16'h0, 3'b0, 1'b0};
    drop0 = 1'b0; drop1 = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (drop0) req0_valid = 1'b0;
      if (drop1) req1_valid = 1'b0;
      drop0 = 1'b0; drop1 = 1'b0;
      if (!req0_valid) begin
        if ($urandom_range(0, 2) == 0)
          drive(1'b0, 1'b1, 3'($urandom_range(0, 7)), 16'($urandom),
                ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15)));
      end else if ($urandom_range(0, 15) == 0) req0_valid = 1'b0;
      if (!req1_valid) begin
        if ($urandom_range(0, 2) == 0)
          drive(1'b1, 1'b1, 3'($urandom_range(0, 7)), 16'($urandom),
                ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15)));
      end else if ($urandom_range(0, 15) == 0) req1_valid = 1'b0;
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_g0 = 1'b0; exp_g1 = 1'b0;
      if (m_phase == 0) begin
        if (req0_valid && req1_valid) begin
          if (m_last == 1) exp_g0 = 1'b1; else exp_g1 = 1'b1;
        end else begin
          exp_g0 = req0_valid; exp_g1 = req1_valid;
        end
      end
      check("r_ready0", req0_ready, exp_g0);
      check("r_ready1", req1_ready, exp_g1);
      check("r_busy", busy, m_phase != 0);
      check("r_rsp_valid", rsp_valid, m_phase == 2);
      check("r_flag_reg", flag_reg, m_fr);
      if (m_phase == 2) begin
        check("r_rsp_data", rsp_data, m_exp.data);
        check("r_rsp_flags", rsp_flags, m_exp.flags);
        check("r_rsp_err", rsp_err, m_exp.err);
        check("r_rsp_id", rsp_id, m_id);
      end
      case (m_phase)
        0: if (exp_g0 || exp_g1) begin
             m_id = exp_g1;
             m_opq = exp_g1 ? req1_op : req0_op;
             r = exp_g1 ? alu_ref(req1_op, req1_a, req1_b) : alu_ref(req0_op, req0_a, req0_b);
             m_exp = r;
             m_last = exp_g1 ? 1 : 0;
             drop0 = exp_g0; drop1 = exp_g1;
             m_phase = 1;
           end
        1: m_phase = 2;
        default: if (rsp_ready) begin
             m_op_arith = (m_opq == 3'd0) || (m_opq == 3'd1);
             m_op_z = (m_opq == 3'd2) || (m_opq == 3'd4) || (m_opq == 3'd5) || (m_opq == 3'd6);
             if (!m_exp.err) begin
               if (m_op_arith) m_fr = m_exp.flags;
               else if (m_op_z) m_fr[2] = m_exp.flags[2];
             end
             m_phase = 0;
           end
      endcase
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
